ula_cmp_ctrl: RTL
=================

# ula_cmp_ctrl

Sequencing controller for the ULA comparison path. It accepts one compare request at a time (EQ / GTE / LTE on two 8-bit operands) over a valid/ready handshake and issues a subtraction to the shared ULA. It then captures the ULA's zero and sign flags and returns the 16-bit compare word on a valid/ready response channel. It sits between the instruction/issue logic and the ULA, and owns timeout and illegal-opcode error reporting for compare operations.

## Interface
- TIMEOUT_CYCLES, 16: maximum cycles in WAIT before aborting; legal range 1..255.
- ULA_OP_SUB, 4'h1: ULA opcode driven on `ula_op` for compare subtraction.
- clk  in  1  single clock; all state is updated on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  2  2'b00 EQ, 2'b01 GTE, 2'b10 LTE, 2'b11 reserved.
- req_a, req_b  in  8 each  compare operands.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_out  out  16  compare word: bit 15 = predicate, bits 14:0 = 0.
- resp_err  out  1  response is an error (timeout or reserved op); `resp_out` = 0 when set.
- ula_start  out  1  one-cycle ULA launch strobe.
- ula_op  out  4  ULA opcode; always ULA_OP_SUB during ISSUE, 0 otherwise.
- ula_x, ula_y  out  8 each  ULA operands: `ula_x` = req_b, `ula_y` = req_a, so the ULA computes b − a.
- ula_done  in  1  ULA result/flags valid this cycle.
- ula_zero, ula_sign  in  1 each  ULA flags, qualified by `ula_done`.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid && req_ready`, latch op, a and b.
  - Reserved op: go to RESP with err = 1. The ULA is not touched.
  - Any other op: go to ISSUE.
- ISSUE:
  - Drive `ula_start` = 1 with `ula_op`/`ula_x`/`ula_y` for exactly one cycle.
  - Clear the timeout counter, then go to WAIT.
- WAIT:
  - On `ula_done`, capture the flags, compute the predicate and go to RESP with err = 0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES, go to RESP with err = 1.
  - If `ula_done` and the limit arrive in the same cycle, `ula_done` wins.
- Predicate (from flags of b − a; sign = 1 means a > b):
  - EQ = zero.
  - GTE = zero | sign.
  - LTE = zero | ~sign.
- RESP:
  - `resp_valid` = 1 with `resp_out`/`resp_err` held stable until `resp_ready`.
  - On handshake, go to IDLE.
- `ula_done` in IDLE, ISSUE or RESP is ignored.
- Flag combinations are not sanity-checked; zero = 1 with sign = 1 yields 1 for GTE and EQ.

## Timing
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.
- Reset values: `req_ready` 0 while `rst` is asserted, 1 on the first cycle after release (IDLE). All other outputs are 0 (`resp_valid`, `resp_err`, `resp_out`, `ula_start`, `ula_op`, `ula_x`, `ula_y`, `busy`).
- Latency, accept at edge 0:
  - `ula_start` is high in cycle 1.
  - The earliest honoured `ula_done` is in cycle 2.
  - `resp_valid` rises in the cycle after `ula_done` (minimum cycle 3).
- Reserved op: `resp_valid` in cycle 1.
- Timeout: `resp_valid` in cycle 2 + TIMEOUT_CYCLES when `ula_done` never arrives.
- Throughput: a new request is accepted the cycle after the response handshake. `req_ready` is low during RESP even when `resp_ready` is high.
- Reset mid-operation: immediately (asynchronously) enter IDLE and drop `ula_start`, `resp_valid` and `busy`. Any in-flight ULA result arriving later is ignored.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1); it never wraps.

## Structure
- Package `ula_cmp_pkg` holds:
  - `cmp_op_t` enum: EQ, GTE, LTE, RSVD.
  - `cmp_state_t` enum: IDLE, ISSUE, WAIT, RESP.
  - Constant `ULA_OP_SUB_DEFAULT`.
- Sub-module `ula_cmp_decode`: combinational (op, zero, sign) → 16-bit word with the predicate in bit 15. It is reused by other compare consumers.
- Top level holds the FSM, operand/op latches, timeout counter and response registers.

## Test plan
- EQ, a=8'h05, b=8'h05; ULA returns done=1, zero=1, sign=0 two cycles after start → `resp_out`=16'h8000, `resp_err`=0, `resp_valid` at cycle 4.
- GTE then LTE, a=8'h09, b=8'h03; ULA returns zero=0, sign=1 each time → 16'h8000 then 16'h0000. Check `ula_x`=8'h03 and `ula_y`=8'h09 during `ula_start`.
- `req_op`=2'b11 → `ula_start` never asserts; `resp_valid` in cycle 1 with `resp_err`=1 and `resp_out`=16'h0000.
- TIMEOUT_CYCLES=4, `ula_done` held low → `resp_err`=1 in cycle 6. A late `ula_done` in RESP/IDLE has no effect.
- `resp_ready` low for 5 cycles → `resp_out` stable and `req_ready`=0 throughout. The next request is accepted one cycle after the handshake.
- `rst` pulsed mid-WAIT → all outputs are 0 asynchronously and `req_ready`=1 after release. A subsequent EQ with equal operands completes normally with 16'h8000.

Source files
------------

// File: rtl/ula_cmp_pkg.sv
// -----------------------------------------------------------------------------
// ula_cmp_pkg
//   Shared types and constants for the ULA compare path.
//   - cmp_op_t     : compare opcode carried on req_op (EQ / GTE / LTE / RSVD)
//   - cmp_state_t  : controller sequencing states
//   - ULA_OP_SUB_DEFAULT : ULA opcode used to launch the b - a subtraction
//   - cmp_predicate(): flag-to-predicate rule, shared by every compare consumer
// -----------------------------------------------------------------------------
package ula_cmp_pkg;

  typedef enum logic [1:0] {
    EQ   = 2'b00,
    GTE  = 2'b01,
    LTE  = 2'b10,
    RSVD = 2'b11
  } cmp_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } cmp_state_t;

  localparam logic [3:0]  ULA_OP_SUB_DEFAULT = 4'h1;
  localparam int unsigned CMP_WORD_W         = 16;
  localparam int unsigned CMP_PRED_BIT       = 15;

  // Flags come from b - a, so sign = 1 means a > b. Flag combinations are
  // taken at face value: zero and sign both set still satisfies EQ and GTE.
  function automatic logic cmp_predicate(input cmp_op_t op,
                                         input logic    zero,
                                         input logic    sign);
    case (op)
      EQ:      return zero;
      GTE:     return zero | sign;
      LTE:     return zero | ~sign;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ula_cmp_ctrl_if.sv
// -----------------------------------------------------------------------------
// ula_cmp_ctrl_if
//   Bundles the three channels of the compare controller:
//   - request  : req_valid/req_ready handshake with req_op, req_a, req_b
//   - response : resp_valid/resp_ready handshake with resp_out, resp_err
//   - ULA      : ula_start/ula_op/ula_x/ula_y launch, ula_done/ula_zero/
//                ula_sign flags back
//   - busy     : controller status
//   Modports:
//   - slave  : the controller itself
//   - master : the surroundings (issue logic, response consumer and ULA)
// -----------------------------------------------------------------------------
interface ula_cmp_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_a;
  logic [7:0]  req_b;

  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_out;
  logic        resp_err;

  logic        ula_start;
  logic [3:0]  ula_op;
  logic [7:0]  ula_x;
  logic [7:0]  ula_y;
  logic        ula_done;
  logic        ula_zero;
  logic        ula_sign;

  logic        busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready,
    output resp_valid, resp_out, resp_err,
    input  resp_ready,
    output ula_start, ula_op, ula_x, ula_y,
    input  ula_done, ula_zero, ula_sign,
    output busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready,
    input  resp_valid, resp_out, resp_err,
    output resp_ready,
    input  ula_start, ula_op, ula_x, ula_y,
    output ula_done, ula_zero, ula_sign,
    input  busy
  );

endinterface

// File: rtl/ula_cmp_decode.sv
// -----------------------------------------------------------------------------
// ula_cmp_decode
//   Purely combinational: turns a compare opcode plus the ULA zero/sign flags
//   of (b - a) into the 16-bit compare word (predicate in bit 15, rest zero).
//   Reserved opcodes decode to an all-zero word.
//   Ports:
//   - op   in  cmp_op_t  compare opcode
//   - zero in  1         ULA zero flag
//   - sign in  1         ULA sign flag
//   - word out 16        compare word
// -----------------------------------------------------------------------------
module ula_cmp_decode
  import ula_cmp_pkg::*;
(
  input  cmp_op_t               op,
  input  logic                  zero,
  input  logic                  sign,
  output logic [CMP_WORD_W-1:0] word
);

  always_comb begin
    // NOTE: the whole word gets a default before the predicate bit is set, so
    // every bit is written on every path and no latch can be inferred.
    word               = '0;
    word[CMP_PRED_BIT] = cmp_predicate(op, zero, sign);
  end

endmodule

// File: rtl/ula_cmp_ctrl.sv
// -----------------------------------------------------------------------------
// ula_cmp_ctrl
//   Sequencing controller for the ULA compare path. Accepts one compare
//   request at a time, launches a b - a subtraction on the shared ULA, turns
//   the returned flags into a compare word and presents it on the response
//   channel. Reserved opcodes and ULA timeouts are reported with resp_err.
//   Parameters:
//   - TIMEOUT_CYCLES : WAIT cycles before giving up on the ULA (1..255)
//   - ULA_OP_SUB     : opcode driven on ula_op during ISSUE
//   Ports:
//   - clk  in   single clock, rising edge
//   - rst  in   asynchronous, active-high reset
//   - bus  slave side of ula_cmp_ctrl_if (request, response, ULA, busy)
//   Every output is a flop, loaded from the next-state decode or from the
//   datapath, so no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module ula_cmp_ctrl
  import ula_cmp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [3:0]  ULA_OP_SUB     = ULA_OP_SUB_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  ula_cmp_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_RESP  = RESP;

  // The counter only has to reach TIMEOUT_CYCLES-1; it stops there because
  // the FSM leaves WAIT on that same edge.
  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  cmp_op_t               op_q;
  logic [CNT_W-1:0]      cnt;

  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic                  busy_q;
  logic                  ula_start_q;
  logic [3:0]            ula_op_q;
  logic [7:0]            ula_x_q;
  logic [7:0]            ula_y_q;
  logic [CMP_WORD_W-1:0] resp_out_q;
  logic                  resp_err_q;

  logic [CMP_WORD_W-1:0] dec_word;
  logic                  accept;
  logic                  req_rsvd;
  logic                  ula_hit;
  logic                  limit_hit;

  // req_ready_q is only ever high in IDLE, so it doubles as the state qualifier.
  assign accept    = req_ready_q & bus.req_valid;
  assign req_rsvd  = (cmp_op_t'(bus.req_op) == RSVD);
  // ula_done outside WAIT is deliberately ignored; inside WAIT it beats the limit.
  assign ula_hit   = (state == S_WAIT) & bus.ula_done;
  assign limit_hit = (state == S_WAIT) & ~bus.ula_done & (cnt == CNT_LAST);

  ula_cmp_decode u_decode (
    .op   (op_q),
    .zero (bus.ula_zero),
    .sign (bus.ula_sign),
    .word (dec_word)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = req_rsvd ? S_RESP : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (ula_hit || limit_hit) state_nxt = S_RESP;
      S_RESP:  if (bus.resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and state-decoded outputs. The decoded outputs are loaded
  // from state_nxt so they line up with the state they describe while staying
  // registered.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      ula_start_q  <= 1'b0;
      ula_op_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement or block order.
      state        <= state_nxt;
      req_ready_q  <= (state_nxt == S_IDLE);
      resp_valid_q <= (state_nxt == S_RESP);
      busy_q       <= (state_nxt != S_IDLE);
      ula_start_q  <= (state_nxt == S_ISSUE);
      ula_op_q     <= (state_nxt == S_ISSUE) ? ULA_OP_SUB : 4'h0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: opcode latch, ULA operands, timeout counter, response word.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are reset as well, not just the FSM,
      // because several of them drive outputs that must read 0 in reset.
      op_q       <= EQ;
      ula_x_q    <= '0;
      ula_y_q    <= '0;
      cnt        <= '0;
      resp_out_q <= '0;
      resp_err_q <= 1'b0;
    end else begin
      // Operands are presented only during ISSUE; ISSUE always follows a
      // non-reserved accept by exactly one edge, so loading them on accept
      // and clearing them on every other edge gives a one-cycle window.
      ula_x_q <= '0;
      ula_y_q <= '0;

      if (accept) begin
        op_q <= cmp_op_t'(bus.req_op);
        if (req_rsvd) begin
          resp_out_q <= '0;
          resp_err_q <= 1'b1;
        end else begin
          ula_x_q <= bus.req_b;
          ula_y_q <= bus.req_a;
        end
      end

      if (state == S_ISSUE) begin
        cnt <= '0;
      end else if ((state == S_WAIT) && !bus.ula_done && (cnt != CNT_LAST)) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (ula_hit) begin
        resp_out_q <= dec_word;
        resp_err_q <= 1'b0;
      end else if (limit_hit) begin
        resp_out_q <= '0;
        resp_err_q <= 1'b1;
      end

      // Clear the word once it has been consumed so stale results never show.
      if ((state == S_RESP) && bus.resp_ready) begin
        resp_out_q <= '0;
        resp_err_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_out   = resp_out_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.ula_start  = ula_start_q;
  assign bus.ula_op     = ula_op_q;
  assign bus.ula_x      = ula_x_q;
  assign bus.ula_y      = ula_y_q;
  assign bus.busy       = busy_q;

endmodule
